// File: rtl/check_collision.sv
// check_collision: probes the board RAM at the four cells of a candidate
// tetromino placement. It stops at the first cell that is off the board or
// already occupied and reports which cell that was.
module check_collision #(
   parameter int unsigned BOARD_W  = 10,
   parameter int unsigned BOARD_H  = 20,
   parameter int unsigned READ_LAT = 1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [4:0] x_anc,
   input  logic [5:0] y_anc,
   input  logic [2:0] block,
   input  logic [1:0] rotation,
   output logic [7:0] ram_addr,
   output logic       rden,
   input  logic [5:0] ram_q,
   output logic       busy,
   output logic       done,
   output logic       collide,
   output logic [1:0] hit_cell,
   output logic       hit_oob
);

   localparam logic [5:0] LP_W6   = 6'(BOARD_W);
   localparam logic [7:0] LP_W8   = 8'(BOARD_W);
   localparam logic [6:0] LP_H7   = 7'(BOARD_H);
   localparam logic [1:0] LP_LAST = 2'(READ_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_t;

   // Pack cell offsets as {y3,y2,y1,y0, x3,x2,x1,x0}; this table is shared
   // with the piece-commit writer.
   function automatic logic [15:0] f_pk(input logic [1:0] x0, input logic [1:0] y0,
                                        input logic [1:0] x1, input logic [1:0] y1,
                                        input logic [1:0] x2, input logic [1:0] y2,
                                        input logic [1:0] x3, input logic [1:0] y3);
      return {y3, y2, y1, y0, x3, x2, x1, x0};
   endfunction

   // Offset table indexed by {block, rotation}.
   function automatic logic [15:0] f_lut(input logic [2:0] blk, input logic [1:0] rot);
      logic [15:0] v;
      v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1);            // O shape
      case ({blk, rot})
         5'd0, 5'd2:   v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0);
         5'd1, 5'd3:   v = f_pk(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3);
         5'd8:         v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1);
         5'd9:         v = f_pk(2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2);
         5'd10:        v = f_pk(2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0);
         5'd11:        v = f_pk(2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2);
         5'd12, 5'd14: v = f_pk(2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1);
         5'd13, 5'd15: v = f_pk(2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2);
         5'd16, 5'd18: v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1);
         5'd17, 5'd19: v = f_pk(2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2);
         5'd20:        v = f_pk(2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1);
         5'd21:        v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2);
         5'd22:        v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1);
         5'd23:        v = f_pk(2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2);
         5'd24:        v = f_pk(2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1);
         5'd25:        v = f_pk(2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2);
         5'd26:        v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1);
         5'd27:        v = f_pk(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2);
         default:      ;
      endcase
      return v;
   endfunction

   state_t     r_state;
   logic [4:0] r_x;
   logic [5:0] r_y;
   logic [2:0] r_block;
   logic [1:0] r_rot;
   logic [1:0] r_k;
   logic [1:0] r_wcnt;
   logic       r_oob;
   logic [7:0] r_ram_addr;
   logic       r_rden;
   logic       r_busy;
   logic       r_done;
   logic       r_collide;
   logic [1:0] r_hit_cell;
   logic       r_hit_oob;

   logic [4:0]  w_x;
   logic [5:0]  w_y;
   logic [2:0]  w_blk;
   logic [1:0]  w_rot;
   logic [1:0]  w_k;
   logic [15:0] w_lut;
   logic [7:0]  w_xoffs;
   logic [7:0]  w_yoffs;
   logic [1:0]  w_dx;
   logic [1:0]  w_dy;
   logic [5:0]  w_cx;
   logic [6:0]  w_cy;
   logic        w_inb;
   logic [7:0]  w_addr;

   // Next cell to probe: cell 0 of the incoming placement while idle,
   // otherwise cell k+1 of the latched placement.
   always_comb begin
      w_x     = (r_state == S_IDLE) ? x_anc    : r_x;
      w_y     = (r_state == S_IDLE) ? y_anc    : r_y;
      w_blk   = (r_state == S_IDLE) ? block    : r_block;
      w_rot   = (r_state == S_IDLE) ? rotation : r_rot;
      w_k     = (r_state == S_IDLE) ? 2'd0     : r_k + 2'd1;
      w_lut   = f_lut(w_blk, w_rot);
      w_xoffs = w_lut[7:0];
      w_yoffs = w_lut[15:8];
      w_dx    = w_xoffs[{w_k, 1'b0} +: 2];
      w_dy    = w_yoffs[{w_k, 1'b0} +: 2];
      w_cx    = {1'b0, w_x} + 6'(w_dx);
      w_cy    = {1'b0, w_y} + 7'(w_dy);
      w_inb   = (w_cx < LP_W6) && (w_cy < LP_H7);
      w_addr  = 8'(w_cy) * LP_W8 + 8'(w_cx);
   end

   // Check sequencer; the read address and strobe are loaded on the edge
   // that enters ADDR so they are valid for the whole ADDR cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_x        <= 5'd0;
         r_y        <= 6'd0;
         r_block    <= 3'd0;
         r_rot      <= 2'd0;
         r_k        <= 2'd0;
         r_wcnt     <= 2'd0;
         r_oob      <= 1'b0;
         r_ram_addr <= 8'd0;
         r_rden     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_collide  <= 1'b0;
         r_hit_cell <= 2'd0;
         r_hit_oob  <= 1'b0;
      end else begin
         r_rden <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x        <= x_anc;
                  r_y        <= y_anc;
                  r_block    <= block;
                  r_rot      <= rotation;
                  r_k        <= 2'd0;
                  r_collide  <= 1'b0;
                  r_hit_cell <= 2'd0;
                  r_hit_oob  <= 1'b0;
                  r_busy     <= 1'b1;
                  r_ram_addr <= w_inb ? w_addr : 8'd0;
                  r_rden     <= w_inb;
                  r_oob      <= ~w_inb;
                  r_state    <= S_ADDR;
               end
            end
            S_ADDR: begin
               r_wcnt <= 2'd0;
               if (r_oob) begin
                  r_collide  <= 1'b1;
                  r_hit_oob  <= 1'b1;
                  r_hit_cell <= r_k;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_wcnt != LP_LAST) begin
                  r_wcnt <= r_wcnt + 2'd1;
               end else if (ram_q != 6'd0) begin
                  r_collide  <= 1'b1;
                  r_hit_oob  <= 1'b0;
                  r_hit_cell <= r_k;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end else if (r_k == 2'd3) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_k        <= w_k;
                  r_ram_addr <= w_inb ? w_addr : 8'd0;
                  r_rden     <= w_inb;
                  r_oob      <= ~w_inb;
                  r_state    <= S_ADDR;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ram_addr = r_ram_addr;
   assign rden     = r_rden;
   assign busy     = r_busy;
   assign done     = r_done;
   assign collide  = r_collide;
   assign hit_cell = r_hit_cell;
   assign hit_oob  = r_hit_oob;

endmodule

// File: tb/tb_check_collision.sv
// Bench for check_collision: one instance with READ_LAT=1 and one with
// READ_LAT=3 against a shared board memory, with a reference placement model.
module tb_check_collision;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start0, start1;
   logic [4:0] x_anc;
   logic [5:0] y_anc;
   logic [2:0] block;
   logic [1:0] rotation;
   logic [7:0] addr0, addr1;
   logic       rden0, rden1, busy0, busy1, done0, done1;
   logic       col0, col1, oob0, oob1;
   logic [1:0] hit0, hit1;
   logic [5:0] q0, q1;

   always #5 clk = ~clk;

   check_collision #(.BOARD_W(10), .BOARD_H(20), .READ_LAT(1)) u_lat1 (
      .clk(clk), .resetn(resetn), .start(start0), .x_anc(x_anc), .y_anc(y_anc),
      .block(block), .rotation(rotation), .ram_addr(addr0), .rden(rden0),
      .ram_q(q0), .busy(busy0), .done(done0), .collide(col0),
      .hit_cell(hit0), .hit_oob(oob0));

   check_collision #(.BOARD_W(10), .BOARD_H(20), .READ_LAT(3)) u_lat3 (
      .clk(clk), .resetn(resetn), .start(start1), .x_anc(x_anc), .y_anc(y_anc),
      .block(block), .rotation(rotation), .ram_addr(addr1), .rden(rden1),
      .ram_q(q1), .busy(busy1), .done(done1), .collide(col1),
      .hit_cell(hit1), .hit_oob(oob1));

   // Board RAM: reads are only meaningful on the rden cycle; otherwise the
   // pipeline carries a poison value.
   logic [5:0] mem [256];
   logic [5:0] p0;
   logic [5:0] p1 [3];
   always @(posedge clk) begin
      p0    <= rden0 ? mem[addr0] : 6'h3F;
      p1[0] <= rden1 ? mem[addr1] : 6'h3F;
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end
   assign q0 = p0;
   assign q1 = p1[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [7:0] addr; int cyc;} rd_t;
   typedef struct {int cyc; logic col; logic [1:0] hit; logic oob;} res_t;

   rd_t  exp_rd[$];
   res_t exp_res[$];
   res_t last_res;
   int   sel = 0;
   int   lat = 1;
   int   since = 100;
   logic [7:0] last_addr = 8'd0;
   int   n_chk = 0;
   int   n_fail = 0;

   // Piece cells as "x0y0x1y1x2y2x3y3", indexed block*4+rotation.
   string shapes [32] = '{
      "00102030", "00010203", "00102030", "00010203",
      "00100111", "00100111", "00100111", "00100111",
      "00102011", "10011112", "01112110", "00011102",
      "10200111", "00011112", "10200111", "00011112",
      "00101121", "10011102", "00101121", "10011102",
      "00011121", "00100102", "00102021", "10110212",
      "20011121", "00010212", "00102001", "00101112",
      "00100111", "00100111", "00100111", "00100111"};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int off(input int blk, input int rot, input int k, input int is_y);
      string s;
      s = shapes[blk * 4 + rot];
      return int'(s[2 * k + is_y]) - 48;
   endfunction

   // Reference model: push expected reads and the expected result.
   task automatic push_expect(input int x, input int y, input int blk, input int rot, input int c0);
      int   cx, cy, step;
      rd_t  r;
      res_t e;
      step = 1 + lat;
      for (int k = 0; k < 4; k++) begin
         cx = x + off(blk, rot, k, 0);
         cy = y + off(blk, rot, k, 1);
         if (cx >= 10 || cy >= 20) begin
            e = '{c0 + k * step + 1, 1'b1, 2'(k), 1'b1};
            break;
         end
         r = '{8'((cy * 10 + cx) & 255), c0 + k * step};
         exp_rd.push_back(r);
         if (mem[r.addr] != 6'd0) begin
            e = '{c0 + (k + 1) * step, 1'b1, 2'(k), 1'b0};
            break;
         end
         if (k == 3) e = '{c0 + 4 * step, 1'b0, 2'd0, 1'b0};
      end
      exp_res.push_back(e);
      last_res = e;
   endtask

   // Output monitor: pops and compares reads and completions as they appear.
   always @(negedge clk) begin
      rd_t  r;
      res_t e;
      logic       m_rden, m_done, m_busy, m_col, m_oob;
      logic [1:0] m_hit;
      logic [7:0] m_addr;
      if (resetn === 1'b1) begin
         m_rden = (sel != 0) ? rden1 : rden0;
         m_done = (sel != 0) ? done1 : done0;
         m_busy = (sel != 0) ? busy1 : busy0;
         m_col  = (sel != 0) ? col1  : col0;
         m_oob  = (sel != 0) ? oob1  : oob0;
         m_hit  = (sel != 0) ? hit1  : hit0;
         m_addr = (sel != 0) ? addr1 : addr0;
         if (m_rden) begin
            if (exp_rd.size() == 0) chk("unexpected_rden", 32'd1, 32'd0);
            else begin
               r = exp_rd.pop_front();
               chk("rd_addr", 32'(m_addr), 32'(r.addr));
               chk("rd_cycle", cyc, r.cyc);
            end
            last_addr = m_addr;
            since = 0;
         end else begin
            since++;
            if (m_busy && since <= lat) chk("addr_hold", 32'(m_addr), 32'(last_addr));
         end
         if (m_done) begin
            if (exp_res.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
               e = exp_res.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("collide", 32'(m_col), 32'(e.col));
               chk("hit_cell", 32'(m_hit), 32'(e.hit));
               chk("hit_oob", 32'(m_oob), 32'(e.oob));
               chk("busy_at_done", 32'(m_busy), 32'd0);
            end
         end
      end
   end

   task automatic start_check(input int x, input int y, input int blk, input int rot);
      @(negedge clk);
      x_anc = 5'(x); y_anc = 6'(y); block = 3'(blk); rotation = 2'(rot);
      if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
      push_expect(x, y, blk, rot, cyc + 1);
      @(posedge clk);
      #1;
      start0 = 1'b0; start1 = 1'b0;
      x_anc = 5'($urandom); y_anc = 6'($urandom);
      block = 3'($urandom); rotation = 2'($urandom);
      @(negedge clk);
      chk("busy_after_start", 32'((sel != 0) ? busy1 : busy0), 32'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 80 && exp_res.size() != 0; i++) @(negedge clk);
      chk("done_timeout", exp_res.size(), 0);
      chk("rd_leftover", exp_rd.size(), 0);
      @(negedge clk);
      chk("hold_collide", 32'((sel != 0) ? col1 : col0), 32'(last_res.col));
      chk("hold_hit_cell", 32'((sel != 0) ? hit1 : hit0), 32'(last_res.hit));
      chk("hold_hit_oob", 32'((sel != 0) ? oob1 : oob0), 32'(last_res.oob));
      chk("idle_done_low", 32'((sel != 0) ? done1 : done0), 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {20'd0, addr0, rden0, busy0, done0, col0, hit0, oob0}, 32'd0);
   endtask

   initial begin
      resetn = 1'b0; start0 = 1'b0; start1 = 1'b0;
      x_anc = 5'd0; y_anc = 6'd0; block = 3'd0; rotation = 2'd0;
      for (int a = 0; a < 256; a++) mem[a] = 6'd0;
      #1;
      chk_zero("reset_outputs");
      chk("reset_outputs_lat3", {20'd0, addr1, rden1, busy1, done1, col1, hit1, oob1}, 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // Empty board, anchor (3,5), several shapes.
      start_check(3, 5, 2, 0); wait_done();
      start_check(3, 5, 5, 3); wait_done();
      start_check(3, 5, 0, 1); wait_done();

      // Occupied cell 2 of T at (3,5) -> address 55.
      mem[55] = 6'd3;
      start_check(3, 5, 2, 0); wait_done();
      mem[55] = 6'd0;

      // Right edge, bottom edge, and widest anchor values.
      start_check(9, 0, 0, 0); wait_done();
      start_check(0, 19, 2, 2); wait_done();
      start_check(31, 63, 1, 0); wait_done();
      start_check(8, 18, 1, 2); wait_done();
      start_check(6, 16, 0, 1); wait_done();
      start_check(7, 16, 0, 1); wait_done();

      // A second start mid-check is ignored.
      mem[64] = 6'd1;
      start_check(3, 5, 2, 0);
      @(negedge clk);
      x_anc = 5'd0; y_anc = 6'd19; block = 3'd2; rotation = 2'd2; start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
      wait_done();
      mem[64] = 6'd0;

      // Reset while waiting on the RAM clears everything at once.
      mem[55] = 6'd5;
      start_check(3, 5, 2, 0);
      @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      chk_zero("reset_mid_wait");
      exp_rd.delete(); exp_res.delete();
      @(negedge clk);
      resetn = 1'b1;
      mem[55] = 6'd0;
      start_check(3, 5, 2, 0); wait_done();

      // Three-cycle RAM latency.
      sel = 1; lat = 3;
      for (int b = 0; b < 7; b++) begin
         start_check(4, 10, b, b % 4); wait_done();
      end
      mem[4 + 10 * 12] = 6'd9;
      start_check(4, 10, 0, 1); wait_done();
      mem[4 + 10 * 12] = 6'd0;
      start_check(9, 3, 4, 0); wait_done();

      // Random boards and placements on both latencies.
      for (int s = 0; s < 2; s++) begin
         sel = s; lat = (s != 0) ? 3 : 1;
         for (int n = 0; n < 8; n++) begin
            for (int a = 0; a < 256; a++)
               mem[a] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            start_check($urandom_range(0, 12), $urandom_range(0, 22),
                        $urandom_range(0, 7), $urandom_range(0, 3));
            wait_done();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
